// File: rtl/stack_link_seq_if.sv
// Handshake and control-strobe bundle between the main control unit and the
// PUSH/POP/JAL sequencer.
//
// Signals:
//   start       request pulse from the control unit
//   op          operation code (00 PUSH, 01 POP, 10 JAL, 11 illegal)
//   busy        sequencer is working on an operation
//   done        one-cycle completion pulse
//   illegal     one-cycle pulse alongside done for op 11
//   regdst_sel  write-destination mux select (0 rt, 1 rd, 2 alt, 3 $sp, 4 $ra)
//   wb_sel      write-back source (0 ALU, 1 MEM, 2 PC)
//   reg_write, mem_read, mem_write, sp_dec, sp_inc, pc_write  datapath strobes
//
// Modports: master = control unit side, slave = sequencer side.
interface stack_link_seq_if;
   logic       start;
   logic [1:0] op;
   logic       busy;
   logic       done;
   logic       illegal;
   logic [2:0] regdst_sel;
   logic [1:0] wb_sel;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic       sp_dec;
   logic       sp_inc;
   logic       pc_write;

   modport master (
      output start, op,
      input  busy, done, illegal, regdst_sel, wb_sel,
      input  reg_write, mem_read, mem_write, sp_dec, sp_inc, pc_write
   );

   modport slave (
      input  start, op,
      output busy, done, illegal, regdst_sel, wb_sel,
      output reg_write, mem_read, mem_write, sp_dec, sp_inc, pc_write
   );
endinterface

// File: rtl/stack_link_seq.sv
// Multicycle Moore sequencer for the register-file operations that target
// fixed registers: PUSH, POP and JAL. The main control unit hands over one
// operation per start pulse and waits for done.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    stack_link_seq_if.slave: start/op in, busy/done/illegal and the
//          datapath selects/strobes out
//
// Parameters:
//   MEM_WAIT  cycles mem_read is held before read data is valid (1..15)
//   CNT_W     width of the wait counter; 2**CNT_W must exceed MEM_WAIT
module stack_link_seq #(
   parameter int MEM_WAIT = 2,
   parameter int CNT_W    = 4
) (
   input logic            clk,
   input logic            reset,
   stack_link_seq_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      PUSH_DEC = 4'd1,
      PUSH_MEM = 4'd2,
      POP_READ = 4'd3,
      POP_WB   = 4'd4,
      POP_INC  = 4'd5,
      JAL_LINK = 4'd6,
      JAL_JUMP = 4'd7,
      DONE_ST  = 4'd8
   } state_t;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic [1:0]       op_q;

   // State register, plus the two pieces of context the states need: the
   // memory-wait counter used only in POP_READ, and the op latched at accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         op_q     <= 2'b00;
      end else begin
         state <= state_next;
         if (state == POP_READ) begin
            if (wait_cnt == WAIT_LAST) begin
               wait_cnt <= '0;
            end else begin
               wait_cnt <= wait_cnt + CNT_W'(1);
            end
         end else begin
            wait_cnt <= '0;
         end
         if ((state == IDLE) && bus.start) begin
            op_q <= bus.op;
         end
      end
   end

   // Next-state logic. Start and op only matter in IDLE, so anything the
   // control unit does while busy is ignored. Illegal ops jump straight to
   // DONE so no strobe is ever raised for them.
   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  2'b00:   state_next = PUSH_DEC;
                  2'b01:   state_next = POP_READ;
                  2'b10:   state_next = JAL_LINK;
                  default: state_next = DONE_ST;
               endcase
            end else begin
               state_next = IDLE;
            end
         end
         PUSH_DEC: state_next = PUSH_MEM;
         PUSH_MEM: state_next = DONE_ST;
         POP_READ: state_next = (wait_cnt == WAIT_LAST) ? POP_WB : POP_READ;
         POP_WB:   state_next = POP_INC;
         POP_INC:  state_next = DONE_ST;
         JAL_LINK: state_next = JAL_JUMP;
         JAL_JUMP: state_next = DONE_ST;
         DONE_ST:  state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Output decode from the current state only. Everything defaults to 0,
   // which also covers IDLE and any unreachable encoding.
   always_comb begin
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      bus.illegal    = 1'b0;
      bus.regdst_sel = 3'd0;
      bus.wb_sel     = 2'd0;
      bus.reg_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.sp_dec     = 1'b0;
      bus.sp_inc     = 1'b0;
      bus.pc_write   = 1'b0;
      case (state)
         PUSH_DEC: begin
            bus.busy       = 1'b1;
            bus.sp_dec     = 1'b1;
            bus.regdst_sel = 3'd3;
            bus.reg_write  = 1'b1;
         end
         PUSH_MEM: begin
            bus.busy      = 1'b1;
            bus.mem_write = 1'b1;
         end
         POP_READ: begin
            bus.busy     = 1'b1;
            bus.mem_read = 1'b1;
         end
         POP_WB: begin
            bus.busy      = 1'b1;
            bus.wb_sel    = 2'd1;
            bus.reg_write = 1'b1;
         end
         POP_INC: begin
            bus.busy       = 1'b1;
            bus.sp_inc     = 1'b1;
            bus.regdst_sel = 3'd3;
            bus.reg_write  = 1'b1;
         end
         JAL_LINK: begin
            bus.busy       = 1'b1;
            bus.regdst_sel = 3'd4;
            bus.wb_sel     = 2'd2;
            bus.reg_write  = 1'b1;
         end
         JAL_JUMP: begin
            bus.busy     = 1'b1;
            bus.pc_write = 1'b1;
         end
         DONE_ST: begin
            bus.busy    = 1'b1;
            bus.done    = 1'b1;
            bus.illegal = (op_q == 2'b11);
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
   end

endmodule
